pnode_frame_checker: RTL and testbench

//  Processing-node front end sitting directly downstream of one in_fifo_network tap
//  (pnode_data/pnode_valid/pnode_ready). It absorbs the tap's ready-latency-1 handshake
//  in a small skid buffer, checks SOP/EOP/channel framing, and keeps per-channel

---
 rtl/pnode_frame_checker.sv | 192 +++++++++++++++++++
 tb/tb_pnode_frame_checker.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pnode_frame_checker.sv
// pnode_frame_checker: takes in the tap's ready-latency-1 stream into a small
// skid buffer, checks SOP/EOP/channel framing and keeps per-channel packet,
// beat and error counters. Beats leave on a ready-latency-0 stream.
// Build option: define PNODE_ERR_DROP_EN to discard malformed beats instead of
// forwarding them with out_err set.
`timescale 1ns/1ps
module pnode_frame_checker #(
  parameter int unsigned SKID_DEPTH = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned ERR_W      = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [141:0]      pnode_data,
  input  logic              pnode_valid,
  output logic              pnode_ready,
  output logic [141:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_err,
  input  logic [1:0]        rd_chan,
  output logic [CNT_W-1:0]  rd_pkt_cnt,
  output logic [CNT_W-1:0]  rd_beat_cnt,
  output logic [ERR_W-1:0]  rd_err_cnt,
  output logic              ovf_sticky
);

  localparam int unsigned DATA_W = 142;
  localparam int unsigned ENT_W  = DATA_W + 1;
  localparam int unsigned PTR_W  = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int unsigned OCC_W  = $clog2(SKID_DEPTH + 1);
  localparam int unsigned NCH    = 4;

`ifdef PNODE_ERR_DROP_EN
  localparam logic ERR_FWD = 1'b0;
`else
  localparam logic ERR_FWD = 1'b1;
`endif

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t             state_q, state_d;
  logic [1:0]         cur_chan_q, cur_chan_d;
  logic               bad_q, bad_d;
  logic [ENT_W-1:0]   mem_q [SKID_DEPTH];
  logic [ENT_W-1:0]   mem_d [SKID_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               pnode_ready_q, pnode_ready_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   pkt_cnt_q [NCH];
  logic [CNT_W-1:0]   pkt_cnt_d [NCH];
  logic [CNT_W-1:0]   beat_cnt_q [NCH];
  logic [CNT_W-1:0]   beat_cnt_d [NCH];
  logic [ERR_W-1:0]   err_cnt_q [NCH];
  logic [ERR_W-1:0]   err_cnt_d [NCH];

  logic [1:0]         in_ch;
  logic               in_sop, in_eop;
  logic               pop, full_blk, accept, push, beat_err;
  logic [ENT_W-1:0]   head;

  assign in_ch  = pnode_data[141:140];
  assign in_sop = pnode_data[129];
  assign in_eop = pnode_data[128];

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Framing FSM, statistics and skid bookkeeping for the beat in this cycle
  always_comb begin
    state_d    = state_q;
    cur_chan_d = cur_chan_q;
    bad_d      = bad_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ovf_d      = ovf_q;
    pkt_cnt_d  = pkt_cnt_q;
    beat_cnt_d = beat_cnt_q;
    err_cnt_d  = err_cnt_q;
    beat_err   = 1'b0;

    pop      = (occ_q != '0) && out_ready;
    full_blk = (occ_q == OCC_W'(SKID_DEPTH)) && !pop;
    accept   = pnode_valid && !full_blk;
    if (pnode_valid && full_blk) ovf_d = 1'b1;

    if (accept) begin
      beat_cnt_d[in_ch] = beat_cnt_q[in_ch] + CNT_W'(1);
      unique case (state_q)
        IDLE: begin
          if (in_sop) begin
            if (in_eop) begin
              pkt_cnt_d[in_ch] = pkt_cnt_q[in_ch] + CNT_W'(1);
            end else begin
              state_d    = IN_PKT;
              cur_chan_d = in_ch;
              bad_d      = 1'b0;
            end
          end else begin
            err_cnt_d[in_ch] = sat_inc(err_cnt_q[in_ch]);
            beat_err         = 1'b1;
          end
        end
        IN_PKT: begin
          if (in_sop) begin
            // Previous packet lost its EOP; the new SOP starts a fresh packet
            err_cnt_d[cur_chan_q] = sat_inc(err_cnt_q[cur_chan_q]);
            bad_d = 1'b0;
            if (in_eop) begin
              pkt_cnt_d[in_ch] = pkt_cnt_q[in_ch] + CNT_W'(1);
              state_d          = IDLE;
            end else begin
              cur_chan_d = in_ch;
            end
          end else if (in_ch != cur_chan_q) begin
            err_cnt_d[cur_chan_q] = sat_inc(err_cnt_q[cur_chan_q]);
            bad_d    = 1'b1;
            beat_err = 1'b1;
          end else begin
            beat_err = bad_q;
            if (in_eop) begin
              if (!bad_q) pkt_cnt_d[cur_chan_q] = pkt_cnt_q[cur_chan_q] + CNT_W'(1);
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    push = accept && (ERR_FWD || !beat_err);
    if (push) begin
      mem_d[wr_ptr_q] = {beat_err & ERR_FWD, pnode_data};
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
    // One beat may already be in flight when ready drops, so keep a slot spare
    pnode_ready_d = (occ_d <= OCC_W'(SKID_DEPTH - 2));
  end

  // State, skid storage and counter registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cur_chan_q    <= '0;
      bad_q         <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      pnode_ready_q <= 1'b0;
      ovf_q         <= 1'b0;
      for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
      for (int c = 0; c < NCH; c++) begin
        pkt_cnt_q[c]  <= '0;
        beat_cnt_q[c] <= '0;
        err_cnt_q[c]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      cur_chan_q    <= cur_chan_d;
      bad_q         <= bad_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      pnode_ready_q <= pnode_ready_d;
      ovf_q         <= ovf_d;
      mem_q         <= mem_d;
      pkt_cnt_q     <= pkt_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign out_data    = head[DATA_W-1:0];
  assign out_err     = head[DATA_W] & ERR_FWD;
  assign out_valid   = (occ_q != '0);
  assign pnode_ready = pnode_ready_q;
  assign ovf_sticky  = ovf_q;
  assign rd_pkt_cnt  = pkt_cnt_q[rd_chan];
  assign rd_beat_cnt = beat_cnt_q[rd_chan];
  assign rd_err_cnt  = err_cnt_q[rd_chan];

endmodule

// File: tb/tb_pnode_frame_checker.sv
// Bench for pnode_frame_checker: directed framing scenarios followed by random
// traffic, all checked against a packet-level reference model.
`timescale 1ns/1ps
module tb_pnode_frame_checker;

  localparam int unsigned D = 4;
`ifdef PNODE_ERR_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n;
  logic [141:0]  pnode_data;
  logic          pnode_valid;
  logic          pnode_ready;
  logic [141:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_err;
  logic [1:0]    rd_chan;
  logic [31:0]   rd_pkt_cnt, rd_beat_cnt;
  logic [15:0]   rd_err_cnt;
  logic          ovf_sticky;

  always #10 clock = ~clock;

  pnode_frame_checker #(.SKID_DEPTH(D), .CNT_W(32), .ERR_W(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .pnode_data(pnode_data), .pnode_valid(pnode_valid), .pnode_ready(pnode_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_err(out_err),
    .rd_chan(rd_chan), .rd_pkt_cnt(rd_pkt_cnt), .rd_beat_cnt(rd_beat_cnt),
    .rd_err_cnt(rd_err_cnt), .ovf_sticky(ovf_sticky)
  );

  typedef struct packed {logic err; logic [141:0] data;} ent_t;

  // Reference model state
  ent_t        q[$];
  logic [31:0] m_pkt [4];
  logic [31:0] m_beat [4];
  logic [15:0] m_err [4];
  int          open_ch;
  bit          bad;
  bit          m_ready, m_ovf, allow;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic err_inc(input int c);
    if (m_err[c] != 16'hFFFF) m_err[c] = m_err[c] + 16'd1;
  endtask

  // Packet-level framing rules; returns whether the beat is malformed
  task automatic model_beat(input int ch, input bit sop, input bit eop, output bit err);
    err = 1'b0;
    m_beat[ch] = m_beat[ch] + 32'd1;
    if (sop) begin
      if (open_ch >= 0) err_inc(open_ch);
      open_ch = -1;
      bad = 1'b0;
      if (eop) m_pkt[ch] = m_pkt[ch] + 32'd1;
      else open_ch = ch;
    end else if (open_ch < 0) begin
      err_inc(ch);
      err = 1'b1;
    end else if (ch != open_ch) begin
      err_inc(open_ch);
      bad = 1'b1;
      err = 1'b1;
    end else begin
      err = bad;
      if (eop) begin
        if (!bad) m_pkt[ch] = m_pkt[ch] + 32'd1;
        open_ch = -1;
      end
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int c = 0; c < 4; c++) begin
      m_pkt[c] = '0; m_beat[c] = '0; m_err[c] = '0;
    end
    open_ch = -1; bad = 1'b0; m_ready = 1'b0; m_ovf = 1'b0; allow = 1'b0;
  endtask

  function automatic logic [141:0] mk(input int ch, input bit sop, input bit eop);
    logic [9:0] meta;
    meta = 10'($urandom);
    return {2'(ch), meta, sop, eop, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_all();
    chk("out_valid", 144'(out_valid), 144'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_data", 144'(out_data), 144'(q[0].data));
      chk("out_err", 144'(out_err), 144'(q[0].err));
    end
    chk("pnode_ready", 144'(pnode_ready), 144'(m_ready));
    chk("ovf_sticky", 144'(ovf_sticky), 144'(m_ovf));
    for (int c = 0; c < 4; c++) begin
      rd_chan = 2'(c);
      #1;
      chk($sformatf("pkt_cnt[%0d]", c), 144'(rd_pkt_cnt), 144'(m_pkt[c]));
      chk($sformatf("beat_cnt[%0d]", c), 144'(rd_beat_cnt), 144'(m_beat[c]));
      chk($sformatf("err_cnt[%0d]", c), 144'(rd_err_cnt), 144'(m_err[c]));
    end
  endtask

  // One clock: drive, advance the model, then compare after the edge
  task automatic step(input bit v, input logic [141:0] d, input bit ordy);
    bit pop, full, err, r_now;
    ent_t e;
    pnode_valid = v; pnode_data = d; out_ready = ordy;
    r_now = m_ready;
    pop  = (q.size() > 0) && ordy;
    full = (q.size() == D) && !pop;
    if (pop) void'(q.pop_front());
    if (v) begin
      if (full) m_ovf = 1'b1;
      else begin
        model_beat(int'(d[141:140]), d[129], d[128], err);
        if (!(DROP && err)) begin
          e.err = DROP ? 1'b0 : err;
          e.data = d;
          q.push_back(e);
        end
      end
    end
    m_ready = (q.size() <= D - 2);
    allow = r_now;
    @(posedge clock);
    @(negedge clock);
    pnode_valid = 1'b0;
    check_all();
  endtask

  task automatic send(input int ch, input bit sop, input bit eop, input bit ordy);
    for (int i = 0; i < 64 && !allow; i++) step(1'b0, '0, ordy);
    if (!allow) begin
      vectors++;
      miscompares++;
      $error("FAIL ready_wait observed=0 expected=1");
    end else begin
      step(1'b1, mk(ch, sop, eop), ordy);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < D + 2; i++) step(1'b0, '0, 1'b1);
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0; pnode_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", 144'(out_valid), 144'(0));
    chk("rst_out_data", 144'(out_data), 144'(0));
    chk("rst_out_err", 144'(out_err), 144'(0));
    chk("rst_pnode_ready", 144'(pnode_ready), 144'(0));
    chk("rst_ovf", 144'(ovf_sticky), 144'(0));
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    check_all();
  endtask

  initial begin
    bit v, ordy, sop, eop;
    int ch, stall;
    reset_n = 1'b0; pnode_valid = 1'b0; pnode_data = '0; out_ready = 1'b0; rd_chan = '0;
    model_reset();
    @(negedge clock);
    do_reset();

    // Single-beat packet on channel 2
    send(2, 1'b1, 1'b1, 1'b1);
    drain();

    // Three-beat packet on channel 1 with downstream stalled, then released
    send(1, 1'b1, 1'b0, 1'b0);
    send(1, 1'b0, 1'b0, 1'b0);
    send(1, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    drain();

    // Orphan middle beat on channel 0
    send(0, 1'b0, 1'b0, 1'b1);
    drain();

    // Missing EOP on channel 3 followed by a proper packet
    send(3, 1'b1, 1'b0, 1'b1);
    send(3, 1'b1, 1'b0, 1'b1);
    send(3, 1'b0, 1'b1, 1'b1);
    drain();

    // Channel switch inside a packet, then the bad packet's own EOP
    send(0, 1'b1, 1'b0, 1'b1);
    send(2, 1'b0, 1'b0, 1'b1);
    send(0, 1'b0, 1'b0, 1'b1);
    send(0, 1'b0, 1'b1, 1'b1);
    drain();

    // Valid forced every cycle while stalled: skid fills, extra beats dropped
    for (int i = 0; i < D + 3; i++) step(1'b1, mk(int'($urandom_range(0, 3)), 1'b1, 1'b1), 1'b0);
    drain();

    // Reset in the middle of a packet, then a clean packet
    send(1, 1'b1, 1'b0, 1'b1);
    send(1, 1'b0, 1'b0, 1'b0);
    do_reset();
    send(1, 1'b1, 1'b0, 1'b1);
    send(1, 1'b0, 1'b1, 1'b1);
    drain();

    // Random traffic with bursts of downstream back-pressure
    stall = 0;
    for (int n = 0; n < 800; n++) begin
      if (n % 50 == 0) stall = int'($urandom_range(0, 1));
      ordy = stall ? ($urandom_range(0, 7) < 2) : ($urandom_range(0, 7) < 7);
      v    = allow && ($urandom_range(0, 3) != 0);
      ch   = (open_ch >= 0 && $urandom_range(0, 9) < 8) ? open_ch : int'($urandom_range(0, 3));
      sop  = (open_ch < 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 1);
      eop  = ($urandom_range(0, 9) < 4);
      step(v, v ? mk(ch, sop, eop) : '0, ordy);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
